// File: rtl/scan_pkg.sv
// Shared constants and types for the scan-chain word FIFOs.
package scan_pkg;

  localparam int SCAN_DATA_W         = 32;
  localparam int SCAN_FIFO_ADDR_W    = 6;
  localparam int SCAN_FIFO_AF_MARGIN = 4;

  typedef logic [SCAN_DATA_W-1:0] scan_word_t;

endpackage

// File: rtl/scan_fifo_ram.sv
// Simple dual-port word RAM for the scan FIFO.
// The array has no reset. Only the read-data register is reset.
// A read and a write to the same address on the same edge return the old word.
module scan_fifo_ram
  import scan_pkg::*;
#(
  parameter int DATA_W = SCAN_DATA_W,
  parameter int ADDR_W = SCAN_FIFO_ADDR_W
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Store the write word; the array is deliberately left without a reset.
  always_ff @(posedge aclk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Registered read port that holds its value when re is low.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)  rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/scan_word_fifo.sv
// Synchronous word FIFO between the AXI master and the scan-chain shifter.
// Define SCAN_FIFO_FWFT_EN for first-word-fall-through reads: the RAM read
// register doubles as a prefetch stage, and level includes the displayed word.
// Without the macro, data_out updates one cycle after an accepted rd_en.
module scan_word_fifo
  import scan_pkg::*;
#(
  parameter int DATA_W    = SCAN_DATA_W,
  parameter int ADDR_W    = SCAN_FIFO_ADDR_W,
  parameter int AF_MARGIN = SCAN_FIFO_AF_MARGIN
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  output logic              full,
  output logic              almost_full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] AF_L    = (ADDR_W+1)'(2**ADDR_W - AF_MARGIN);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  logic [ADDR_W:0] wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
  logic            empty_q, empty_d, full_q, full_d, af_q, af_d;
  logic            ovf_q, ovf_d, udf_q, udf_d;
  logic            rd_accept, wr_accept, ram_re;

`ifdef SCAN_FIFO_FWFT_EN
  logic dv_q, dv_d;
  // A word sits in the read register whenever dv_q is set; refill it when it
  // is empty or being acknowledged and the RAM still holds words.
  assign rd_accept = rd_en && dv_q;
  assign ram_re    = !flush && (wptr_q != rptr_q) && (!dv_q || rd_en);
`else
  assign rd_accept = rd_en && !empty_q;
  assign ram_re    = !flush && rd_accept;
`endif

  assign wr_accept = wr_en && (!full_q || rd_accept);

  // Next pointers, sticky flags and status; flush overrides any transfer.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
`ifdef SCAN_FIFO_FWFT_EN
    dv_d   = dv_q;
`endif
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      ovf_d  = 1'b0;
      udf_d  = 1'b0;
`ifdef SCAN_FIFO_FWFT_EN
      dv_d   = 1'b0;
`endif
    end else begin
      if (wr_accept)           wptr_d = wptr_q + ONE_L;
      if (ram_re)              rptr_d = rptr_q + ONE_L;
      if (wr_en && !wr_accept) ovf_d  = 1'b1;
      if (rd_en && empty_q)    udf_d  = 1'b1;
`ifdef SCAN_FIFO_FWFT_EN
      if (ram_re)              dv_d   = 1'b1;
      else if (rd_accept)      dv_d   = 1'b0;
`endif
    end
`ifdef SCAN_FIFO_FWFT_EN
    level_d = (wptr_d - rptr_d) + {{ADDR_W{1'b0}}, dv_d};
    empty_d = !dv_d;
`else
    level_d = wptr_d - rptr_d;
    empty_d = (level_d == '0);
`endif
    full_d = (level_d == DEPTH_L);
    af_d   = (level_d >= AF_L);
  end

  // Pointer and registered status update.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
`ifdef SCAN_FIFO_FWFT_EN
      dv_q    <= 1'b0;
`endif
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
`ifdef SCAN_FIFO_FWFT_EN
      dv_q    <= dv_d;
`endif
    end
  end

  scan_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .aclk   (aclk),
    .areset (areset),
    .we     (wr_accept && !flush),
    .waddr  (wptr_q[ADDR_W-1:0]),
    .wdata  (data_in),
    .re     (ram_re),
    .raddr  (rptr_q[ADDR_W-1:0]),
    .rdata  (data_out)
  );

  assign level       = level_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;

endmodule

// File: tb/tb_scan_word_fifo.sv
// Self-checking bench for scan_word_fifo. A queue model tracks contents and
// flags; accepted reads push the expected word into a scoreboard that a
// separate monitor drains on the falling edge.
module tb_scan_word_fifo;
  import scan_pkg::*;

  localparam int DEPTH = 64;

  logic       aclk = 1'b0;
  logic       areset = 1'b1;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  scan_word_t data_in = '0;
  scan_word_t data_out;
  logic       full, almost_full, empty, overflow, underflow;
  logic [6:0] level;

  int errors = 0;
  int checks = 0;

  scan_word_t mq[$];
  scan_word_t sb[$];
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;
  scan_word_t last_read = '0;

  always #5 aclk = ~aclk;

  scan_word_fifo dut (
    .aclk        (aclk),
    .areset      (areset),
    .flush       (flush),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .full        (full),
    .almost_full (almost_full),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .empty       (empty),
    .level       (level),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_status();
    chk("level", 32'(level), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= DEPTH - 4));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
  endtask

  // One clock of stimulus; the model updates on the same edge as the DUT.
  task automatic step(bit w, scan_word_t d, bit r, bit f);
    bit m_full, m_empty, rd_acc, wr_acc;
    wr_en = w; data_in = d; rd_en = r; flush = f;
    @(posedge aclk);
    m_full  = (mq.size() == DEPTH);
    m_empty = (mq.size() == 0);
    if (f) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      rd_acc = r && !m_empty;
      wr_acc = w && (!m_full || rd_acc);
      if (r && m_empty) m_udf = 1'b1;
      if (w && !wr_acc) m_ovf = 1'b1;
      if (rd_acc) begin
        last_read = mq.pop_front();
        sb.push_back(last_read);
      end
      if (wr_acc) mq.push_back(d);
    end
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    chk_status();
  endtask

  // Read data appears after the accepted edge; compare before the next edge.
  always @(negedge aclk) begin : monitor
    scan_word_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rd_data", data_out, e);
    end
  end

  initial begin
    #12;
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_almost_full", 32'(almost_full), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_underflow", 32'(underflow), 32'h0);
    areset = 1'b0;
    @(posedge aclk); #1;

`ifdef SCAN_FIFO_FWFT_EN
    wr_en = 1'b1; data_in = 32'h1111_1111;
    @(posedge aclk); #1;
    wr_en = 1'b0;
    chk("t6_empty_edge1", 32'(empty), 32'h1);
    @(posedge aclk); #1;
    chk("t6_empty_edge2", 32'(empty), 32'h0);
    chk("t6_data_out", data_out, 32'h1111_1111);
    chk("t6_level", 32'(level), 32'h1);
    rd_en = 1'b1;
    @(posedge aclk); #1;
    rd_en = 1'b0;
    chk("t6_empty_pop", 32'(empty), 32'h1);
    chk("t6_level_pop", 32'(level), 32'h0);
    chk("t6_underflow", 32'(underflow), 32'h0);
`else
    // T1 fill and drain in order
    for (int i = 0; i < DEPTH; i++) step(1'b1, scan_word_t'(i), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // T2 overflow on full, then flush
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h100 + i, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);

    // T3 underflow from empty, then underflow with a same-cycle write
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t3_data_out_hold", data_out, last_read);
    step(1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0);
    chk("t3_data_out_hold2", data_out, last_read);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // T4 simultaneous read/write at full, then random traffic across wrap
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h200 + i, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h300 + i, 1'b1, 1'b0);
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), scan_word_t'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    while (mq.size() > 0) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // T5 asynchronous reset mid-cycle at level 17
    for (int i = 0; i < 17; i++) step(1'b1, 32'h400 + i, 1'b0, 1'b0);
    #2;
    areset = 1'b1;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    last_read = '0;
    chk("t5_empty", 32'(empty), 32'h1);
    chk("t5_level", 32'(level), 32'h0);
    chk("t5_data_out", data_out, 32'h0);
    #3;
    areset = 1'b0;
    @(posedge aclk); #1;
    step(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    step(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
`endif

    @(posedge aclk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
